memory_arbiter: RTL and testbench



---
 rtl/cpu_pkg.sv | 11 +
 rtl/rr_arbiter2.sv | 22 ++
 rtl/memory_arbiter.sv | 109 ++++++++++
 tb/tb_memory_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, memory depth, arbiter FSM states and port indices
// for the simple CPU memory subsystem.
package cpu_pkg;
    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 12;
    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam logic P_CPU   = 1'b0;
    localparam logic P_LD    = 1'b1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-input round-robin picker; the port that won last loses a tie.
// The grant vector is combinational; `last` only moves when en qualifies a grant.
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic last_q, last_d;
    logic pick1;

    always_comb begin
        pick1  = req[1] && (!req[0] || !last_q);
        gnt    = {pick1, req[0] && !pick1};
        last_d = (en && |req) ? pick1 : last_q;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) last_q <= 1'b1;
        else          last_q <= last_d;
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: owns the 64x12 unified memory and serialises CPU (port 0)
// and loader (port 1) accesses with a registered round-robin handshake.
module memory_arbiter
    import cpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic              p0_wack,
    output logic              p1_wack,
    output logic [DATA_W-1:0] rdata,
    output logic              busy
);
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    state_t            st_q, st_d;
    logic              win_q, win_d, we_q, we_d, busy_q, busy_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]        gnt_q, gnt_d, rvalid_q, rvalid_d, wack_q, wack_d;
    logic [1:0]        arb_gnt;
    logic              arb_en;

    // Requests are ignored during ACCESS, so the picker is only enabled outside it.
    assign arb_en = st_q != ACCESS;

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .en      (arb_en),
        .req     ({p1_req, p0_req}),
        .gnt     (arb_gnt)
    );

    always_comb begin
        st_d     = IDLE;
        win_d    = win_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        gnt_d    = '0;
        rvalid_d = '0;
        wack_d   = '0;
        if (st_q == ACCESS) begin
            st_d            = RESP;
            rvalid_d[win_q] = !we_q;
            wack_d[win_q]   = we_q;
            if (!we_q) rdata_d = mem[addr_q];
        end else if (|arb_gnt) begin
            st_d    = ACCESS;
            win_d   = arb_gnt[P_LD];
            we_d    = win_d ? p1_we    : p0_we;
            addr_d  = win_d ? p1_addr  : p0_addr;
            wdata_d = win_d ? p1_wdata : p0_wdata;
            gnt_d   = arb_gnt;
        end
        busy_d = st_d != IDLE;
    end

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            st_q     <= IDLE;
            win_q    <= P_CPU;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            wack_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            st_q     <= st_d;
            win_q    <= win_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            wack_q   <= wack_d;
            busy_q   <= busy_d;
        end

    // Array is deliberately left out of reset; the loader initialises it.
    always_ff @(posedge clock)
        if (st_q == ACCESS && we_q) mem[addr_q] <= wdata_q;

    assign p0_gnt    = gnt_q[P_CPU];
    assign p1_gnt    = gnt_q[P_LD];
    assign p0_rvalid = rvalid_q[P_CPU];
    assign p1_rvalid = rvalid_q[P_LD];
    assign p0_wack   = wack_q[P_CPU];
    assign p1_wack   = wack_q[P_LD];
    assign rdata     = rdata_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: scoreboard-driven bench; every response is matched against
// a queue of expected (port, kind, data) entries pushed when requests are issued.
module tb_memory_arbiter;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
    logic [5:0]  p0_addr = '0, p1_addr = '0;
    logic [11:0] p0_wdata = '0, p1_wdata = '0;
    logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_wack, p1_wack, busy;
    logic [11:0] rdata;

    typedef struct {
        bit          port;
        bit          we;
        logic [11:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t m_e;
    int   errs = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    memory_arbiter dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p0_gnt    (p0_gnt),
        .p1_gnt    (p1_gnt),
        .p0_rvalid (p0_rvalid),
        .p1_rvalid (p1_rvalid),
        .p0_wack   (p0_wack),
        .p1_wack   (p1_wack),
        .rdata     (rdata),
        .busy      (busy)
    );

    // Response monitor: pops the scoreboard on every rvalid/wack pulse.
    always @(negedge clock) begin
        if (reset_n) begin
            checks++;
            if ((p0_gnt && p1_gnt) || ($countones({p0_rvalid, p1_rvalid, p0_wack, p1_wack}) > 1)
                || ((p0_gnt || p1_gnt) && (p0_rvalid || p1_rvalid || p0_wack || p1_wack))) begin
                errs++;
                $display("FAIL exclusivity: gnt=%b%b rvalid=%b%b wack=%b%b required at most one pulse, no overlap",
                         p1_gnt, p0_gnt, p1_rvalid, p0_rvalid, p1_wack, p0_wack);
            end
            if (p0_rvalid || p1_rvalid || p0_wack || p1_wack) begin
                checks++;
                if (sb.size() == 0) begin
                    errs++;
                    $display("FAIL unexpected_resp: rvalid=%b%b wack=%b%b with empty scoreboard",
                             p1_rvalid, p0_rvalid, p1_wack, p0_wack);
                end else begin
                    m_e = sb.pop_front();
                    if ((p1_rvalid || p1_wack) !== m_e.port || (p0_wack || p1_wack) !== m_e.we
                        || (!m_e.we && rdata !== m_e.data)) begin
                        errs++;
                        $display("FAIL resp: got port=%0d we=%0d rdata=%h, expected port=%0d we=%0d rdata=%h",
                                 p1_rvalid || p1_wack, p0_wack || p1_wack, rdata, m_e.port, m_e.we, m_e.data);
                    end
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input bit port, input bit we, input logic [11:0] d);
        exp_t e;
        e.port = port;
        e.we   = we;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic drive(input bit port, input bit req, input bit we, input logic [5:0] a, input logic [11:0] d);
        if (port) begin
            p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
        end else begin
            p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
        end
    endtask

    task automatic apply_reset();
        p0_req = 1'b0;
        p1_req = 1'b0;
        reset_n = 1'b0;
        cyc();
        cyc();
        reset_n = 1'b1;
        cyc();
    endtask

    // For reads, d is the expected read data; for writes, the write data.
    task automatic do_access(input bit port, input bit we, input logic [5:0] a, input logic [11:0] d,
                             output int lat, output bit resp);
        push(port, we, d);
        drive(port, 1'b1, we, a, d);
        lat = -1;
        for (int i = 1; i <= 10 && lat < 0; i++) begin
            cyc();
            if (port ? p1_gnt : p0_gnt) lat = i;
        end
        drive(port, 1'b0, we, a, d);
        cyc();
        resp = port ? (we ? p1_wack : p1_rvalid) : (we ? p0_wack : p0_rvalid);
        cyc();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cyc();
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_wack, p1_wack, busy} !== 7'b0) begin
            errs++;
            $display("FAIL reset_outputs: got %b required 0000000",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_wack, p1_wack, busy});
        end
        checks++;
        if (rdata !== 12'h000) begin
            errs++;
            $display("FAIL reset_rdata: got %h required 000", rdata);
        end
        reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_single_read();
        int lat;
        bit resp;
        do_access(1'b1, 1'b1, 6'd30, 12'h803, lat, resp);
        do_access(1'b0, 1'b0, 6'd30, 12'h803, lat, resp);
        checks++;
        if (lat !== 1) begin
            errs++;
            $display("FAIL single_read_gnt_latency: got %0d required 1", lat);
        end
        checks++;
        if (resp !== 1'b1) begin
            errs++;
            $display("FAIL single_read_rvalid: got %b required 1", resp);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit resp;
        do_access(1'b1, 1'b1, 6'd5, 12'h055, lat, resp);
        drive(1'b1, 1'b1, 1'b1, 6'd5, 12'h123);
        cyc();
        checks++;
        if (p1_gnt !== 1'b1 || busy !== 1'b1) begin
            errs++;
            $display("FAIL reset_mid_gnt: got gnt=%b busy=%b required 1 1", p1_gnt, busy);
        end
        reset_n = 1'b0;
        p1_req = 1'b0;
        #1;
        checks++;
        if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_wack, p1_wack, busy} !== 7'b0) begin
            errs++;
            $display("FAIL reset_mid_outputs: got %b required 0000000",
                     {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_wack, p1_wack, busy});
        end
        cyc();
        reset_n = 1'b1;
        cyc();
        do_access(1'b0, 1'b0, 6'd5, 12'h055, lat, resp);
        checks++;
        if (lat !== 1 || resp !== 1'b1) begin
            errs++;
            $display("FAIL reset_mid_reread: got lat=%0d resp=%b required 1 1", lat, resp);
        end
    endtask

    task automatic test_tie();
        apply_reset();
        push(1'b0, 1'b0, 12'h803);
        push(1'b1, 1'b0, 12'h055);
        drive(1'b0, 1'b1, 1'b0, 6'd30, 12'h000);
        drive(1'b1, 1'b1, 1'b0, 6'd5, 12'h000);
        cyc();
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b01) begin
            errs++;
            $display("FAIL tie_first_gnt: got %b required 01", {p1_gnt, p0_gnt});
        end
        p0_req = 1'b0;
        cyc();
        checks++;
        if ({p1_gnt, p0_gnt, p1_rvalid, p0_rvalid} !== 4'b0001) begin
            errs++;
            $display("FAIL tie_p0_resp: got %b required 0001", {p1_gnt, p0_gnt, p1_rvalid, p0_rvalid});
        end
        cyc();
        checks++;
        if ({p1_gnt, p0_gnt} !== 2'b10) begin
            errs++;
            $display("FAIL tie_second_gnt: got %b required 10", {p1_gnt, p0_gnt});
        end
        p1_req = 1'b0;
        cyc();
        checks++;
        if ({p1_rvalid, p0_rvalid} !== 2'b10) begin
            errs++;
            $display("FAIL tie_p1_resp: got %b required 10", {p1_rvalid, p0_rvalid});
        end
        cyc();
    endtask

    task automatic test_sustained();
        apply_reset();
        for (int k = 0; k < 8; k++) push(k[0], 1'b0, k[0] ? 12'h055 : 12'h803);
        drive(1'b0, 1'b1, 1'b0, 6'd30, 12'h000);
        drive(1'b1, 1'b1, 1'b0, 6'd5, 12'h000);
        for (int k = 0; k < 8; k++) begin
            cyc();
            checks++;
            if ({p1_gnt, p0_gnt} !== (k[0] ? 2'b10 : 2'b01)) begin
                errs++;
                $display("FAIL sustained_gnt[%0d]: got %b required %b", k, {p1_gnt, p0_gnt},
                         k[0] ? 2'b10 : 2'b01);
            end
            if (k == 7) begin
                p0_req = 1'b0;
                p1_req = 1'b0;
            end
            cyc();
            checks++;
            if ({p1_gnt, p0_gnt} !== 2'b00) begin
                errs++;
                $display("FAIL sustained_gap[%0d]: got %b required 00", k, {p1_gnt, p0_gnt});
            end
        end
        cyc();
    endtask

    task automatic test_boundary();
        bit          port_t [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        bit          we_t   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic [5:0]  addr_t [4] = '{6'd63, 6'd0, 6'd63, 6'd0};
        logic [11:0] data_t [4] = '{12'hFFF, 12'h001, 12'hFFF, 12'h001};
        int lat;
        bit resp;
        for (int i = 0; i < 4; i++) begin
            do_access(port_t[i], we_t[i], addr_t[i], data_t[i], lat, resp);
            checks++;
            if (lat !== 1 || resp !== 1'b1) begin
                errs++;
                $display("FAIL boundary[%0d]: got lat=%0d resp=%b required 1 1", i, lat, resp);
            end
        end
    endtask

    task automatic test_back_to_back();
        push(1'b0, 1'b1, 12'h41E);
        push(1'b0, 1'b0, 12'h41E);
        drive(1'b0, 1'b1, 1'b1, 6'd12, 12'h41E);
        cyc();
        checks++;
        if (p0_gnt !== 1'b1) begin
            errs++;
            $display("FAIL b2b_write_gnt: got %b required 1", p0_gnt);
        end
        drive(1'b0, 1'b1, 1'b0, 6'd12, 12'h000);
        cyc();
        checks++;
        if (p0_wack !== 1'b1) begin
            errs++;
            $display("FAIL b2b_wack: got %b required 1", p0_wack);
        end
        cyc();
        checks++;
        if (p0_gnt !== 1'b1) begin
            errs++;
            $display("FAIL b2b_read_gnt: got %b required 1", p0_gnt);
        end
        p0_req = 1'b0;
        cyc();
        checks++;
        if (p0_rvalid !== 1'b1 || rdata !== 12'h41E) begin
            errs++;
            $display("FAIL b2b_rvalid: got rvalid=%b rdata=%h required 1 41e", p0_rvalid, rdata);
        end
        cyc();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_read();
        test_reset_mid();
        test_tie();
        test_sustained();
        test_boundary();
        test_back_to_back();
        cyc();
        checks++;
        if (sb.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
